// File: rtl/rv32_mod_muldiv_if.sv
// rtl/rv32_mod_muldiv_if.sv - request/response bundle between the core and the muldiv unit
//
// Signals:
//   start       request strobe from the core
//   func        funct3 of the M-extension op
//   kill        pipeline flush, aborts any in-flight op
//   read0_data  rs1 operand
//   read1_data  rs2 operand
//   stall       core holds the instruction while high
//   valid       one-cycle result strobe
//   result      registered result word
// master = core side, slave = muldiv unit side.
interface rv32_mod_muldiv_if;
  logic        start;
  logic [2:0]  func;
  logic        kill;
  logic [31:0] read0_data;
  logic [31:0] read1_data;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  modport master (
    output start, func, kill, read0_data, read1_data,
    input  stall, valid, result
  );

  modport slave (
    input  start, func, kill, read0_data, read1_data,
    output stall, valid, result
  );
endinterface

// File: rtl/rv32_mod_muldiv.sv
// rtl/rv32_mod_muldiv.sv - iterative RV32M multiply/divide unit
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rv32_mod_muldiv_if.slave (start/func/kill/operands in, stall/valid/result out)
//
// Optional feature macro: RV32_MULDIV_FAST_MUL_EN
//   defined   - MUL* ops use a single-cycle 64-bit product and finish in 2 cycles
//   undefined - MUL* ops use the 32-step shift-add loop (34-cycle latency)
module rv32_mod_muldiv (
  input  logic              clk,
  input  logic              rst_n,
  rv32_mod_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [2:0]  func_q;
  logic [31:0] opb_q;      // multiplicand magnitude or divisor magnitude
  logic [31:0] hi_q;       // product high word / partial remainder
  logic [31:0] lo_q;       // multiplier bits / dividend bits shifting into quotient
  logic        neg_q;      // negate product or quotient in FIX
  logic        neg_rem_q;  // negate remainder in FIX (dividend sign)
  logic [4:0]  cnt_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic        signed_a, signed_b, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        accept, fast, div_zero, div_ovf;
  logic [31:0] fast_result;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;
`ifdef RV32_MULDIV_FAST_MUL_EN
  logic [63:0] fm_prod;
`endif

  always_comb begin
    // MUL (000) only needs the low word, which is sign-agnostic, so it is treated as unsigned.
    signed_a = (bus.func == 3'b001) || (bus.func == 3'b010) ||
               (bus.func == 3'b100) || (bus.func == 3'b110);
    signed_b = (bus.func == 3'b001) || (bus.func == 3'b100) || (bus.func == 3'b110);
    sa       = signed_a && bus.read0_data[31];
    sb       = signed_b && bus.read1_data[31];
    mag_a    = sa ? (32'd0 - bus.read0_data) : bus.read0_data;
    mag_b    = sb ? (32'd0 - bus.read1_data) : bus.read1_data;

    accept   = bus.start && !bus.kill && ((state_q == S_IDLE) || (state_q == S_DONE));
    div_zero = (bus.read1_data == 32'd0);
    div_ovf  = !bus.func[0] && (bus.read0_data == 32'h8000_0000) &&
               (bus.read1_data == 32'hFFFF_FFFF);
    fast     = bus.func[2] && (div_zero || div_ovf);

    // func[1] selects remainder among the divide ops.
    if (div_zero) fast_result = bus.func[1] ? bus.read0_data : 32'hFFFF_FFFF;
    else          fast_result = bus.func[1] ? 32'd0 : 32'h8000_0000;

    // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    // One restoring-divide step: bring in the next dividend bit and trial-subtract.
    div_shift = {hi_q, lo_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});

    prod_fix = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    quo_fix  = neg_q ? (32'd0 - lo_q) : lo_q;
    rem_fix  = neg_rem_q ? (32'd0 - hi_q) : hi_q;
    case (func_q)
      3'b000:                 fix_result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase

`ifdef RV32_MULDIV_FAST_MUL_EN
    // Low 64 bits of the product of sign-extended operands equal the exact 33x33 signed product.
    fm_prod = {{32{sa}}, bus.read0_data} * {{32{sb}}, bus.read1_data};
`endif
  end

  assign bus.stall  = (state_q == S_CALC) || (state_q == S_FIX) || (accept && !fast);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      func_q    <= 3'd0;
      opb_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= 5'd0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      if (bus.kill) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (accept) begin
              func_q    <= bus.func;
              opb_q     <= mag_b;
              hi_q      <= 32'd0;
              lo_q      <= mag_a;
              neg_q     <= sa ^ sb;
              neg_rem_q <= sa;
              cnt_q     <= 5'd0;
              if (fast) begin
                result_q <= fast_result;
                valid_q  <= 1'b1;
                state_q  <= S_DONE;
              end else begin
`ifdef RV32_MULDIV_FAST_MUL_EN
                if (!bus.func[2]) begin
                  hi_q    <= fm_prod[63:32];
                  lo_q    <= fm_prod[31:0];
                  neg_q   <= 1'b0;
                  state_q <= S_FIX;
                end else begin
                  state_q <= S_CALC;
                end
`else
                state_q <= S_CALC;
`endif
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_CALC: begin
            if (!func_q[2]) begin
              hi_q <= mul_sum[32:1];
              lo_q <= {mul_sum[0], lo_q[31:1]};
            end else begin
              hi_q <= div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
              lo_q <= {lo_q[30:0], div_ge};
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIX;
          end
          S_FIX: begin
            result_q <= fix_result;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/rv32_mod_muldiv.md
Name: rv32_mod_muldiv

Overview:
- Iterative RV32M multiply/divide unit for the rv32imc_ss execute stage; the multi-cycle counterpart to the single-cycle ALU.
- Accepts an M-extension request, raises `stall` to hold the pipeline, computes for up to 34 cycles, then returns the result with a one-cycle `valid` pulse.
- The core issues requests; this block responds. Operand data comes from the same register-read path that feeds the ALU.

Parameters:
- None. Width is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only when state is IDLE or DONE.
- func  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- kill  in  1  abort an in-flight op (pipeline flush).
- read0_data  in  32  rs1 operand.
- read1_data  in  32  rs2 operand.
- stall  out  1  core must hold the instruction while high.
- valid  out  1  one-cycle pulse; result is valid.
- result  out  32  registered result; held until the next accepted start.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, stall=0, valid=0, result=0, counter=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- Accept:
  - start=1 in IDLE or DONE latches func, operands, operand signs and the negate flags.
  - Operands are converted to magnitudes per func signedness. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Next state is CALC with counter=0.
- Fast path, DIV/DIVU/REM/REMU only; goes directly to DONE, so `valid` rises the cycle after the accept edge:
  - divisor==0: quotient=0xFFFFFFFF, remainder=rs1.
  - signed DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- CALC: 32 iterations, one bit per cycle, counter 0..31; at counter==31 go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, building quotient and remainder.
- FIX:
  - Apply sign correction.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Multiply product is negated per the latched flag.
  - Select the low word (MUL) or high word (MULH*).
  - Register result; go to DONE.
- DONE: valid=1 for exactly one cycle.
  - Next state is IDLE, or CALC/DONE if a new start is accepted in the same cycle (back-to-back allowed).
- Latency: accept edge E0 → valid high during the cycle after E33 (34 cycles). Fast path: 1 cycle.
- stall, combinational:
  - High when state is CALC or FIX.
  - Also high when start is accepted and the op is not fast-path.
  - Low in DONE and IDLE otherwise.
- start while in CALC/FIX: ignored, no side effects.
- kill:
  - In any state, kill=1 forces IDLE on the next edge.
  - valid is not produced and result is unchanged.
  - kill has priority over a simultaneous start.
- Reset mid-operation: immediate return to reset values; no valid pulse.
- Operand inputs are sampled only at accept; changes afterward have no effect.

Optional Feature:
- Macro: RV32_MULDIV_FAST_MUL_EN
- Defined:
  - MUL* ops compute a single-cycle 64-bit signed/unsigned product at the accept edge, using 33x33 signed extension.
  - They go to FIX, then DONE: valid arrives 2 cycles after accept.
  - Divide path is unchanged.
- Undefined: iterative multiply as above, 34-cycle latency; no hardware multiplier is inferred.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → result=0xFFFFFFEB.
  - valid exactly 34 cycles after accept; stall high from the accept cycle through FIX.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with valid 1 cycle after accept and stall never high.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Back-to-back and ignore-while-busy:
  - start DIVU 9/3 in the DONE cycle of a prior op → second valid with 3.
  - start pulsed mid-CALC → ignored, result unchanged.
- kill at counter=10 → IDLE next cycle, no valid, result retains its prior value.
  - rst_n low mid-CALC → outputs 0 immediately.
  - With RV32_MULDIV_FAST_MUL_EN, MUL 6 × 7 → 42 with valid 2 cycles after accept.
